// File: rtl/textram_pkg.sv
// Shared definitions for the text/colour RAM: byte width, fill FSM states and
// an elaboration-time log2 helper.
package textram_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_RUN  = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/textram_if.sv
// Byte-wide CPU request/acknowledge bus of the text/colour RAM.
interface textram_if import textram_pkg::*; #(
  parameter int CPU_AW = 12
);

  logic              cpu_req;
  logic              cpu_wr;
  logic [CPU_AW-1:0] cpu_addr;
  logic [BYTE_W-1:0] cpu_wrdata;
  logic [BYTE_W-1:0] cpu_rddata;
  logic              cpu_ack;

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wrdata,
    input  cpu_rddata, cpu_ack
  );

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wrdata,
    output cpu_rddata, cpu_ack
  );

endinterface

// File: rtl/textram_fill.sv
// Fill engine: writes fill_value over fill_len consecutive bytes (wrapping),
// one byte per cycle in which port A is granted to it.
module textram_fill import textram_pkg::*; #(
  parameter int CPU_AW = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fill_start,
  input  logic [CPU_AW-1:0] fill_addr,
  input  logic [CPU_AW:0]   fill_len,
  input  logic [BYTE_W-1:0] fill_value,
  input  logic              i_grant,
  output logic              o_wr_req,
  output logic [CPU_AW-1:0] o_wr_addr,
  output logic [BYTE_W-1:0] o_wr_data,
  output logic              fill_busy,
  output logic              fill_done
);

  fill_state_e       r_state;
  fill_state_e       w_state_nxt;
  logic              w_load;
  logic              w_step;
  logic [CPU_AW-1:0] r_addr;
  logic [CPU_AW:0]   r_remain;
  logic [BYTE_W-1:0] r_value;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= FILL_IDLE;
    else          r_state <= w_state_nxt;
  end

  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      FILL_IDLE: begin
        if (fill_start) begin
          w_load      = 1'b1;
          w_state_nxt = (fill_len == '0) ? FILL_DONE : FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (i_grant) begin
          w_step = 1'b1;
          if (r_remain == (CPU_AW+1)'(1)) w_state_nxt = FILL_DONE;
        end
      end
      FILL_DONE: w_state_nxt = FILL_IDLE;
      default:   w_state_nxt = FILL_IDLE;
    endcase
  end

  // Counters need no reset: they are only observed while the FSM is in RUN.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_addr   <= fill_addr;
      r_remain <= fill_len;
      r_value  <= fill_value;
    end else if (w_step) begin
      r_addr   <= r_addr + 1'b1;
      r_remain <= r_remain - 1'b1;
    end
  end

  assign o_wr_req  = (r_state == FILL_RUN);
  assign o_wr_addr = r_addr;
  assign o_wr_data = r_value;
  assign fill_busy = (r_state == FILL_RUN);
  assign fill_done = (r_state == FILL_DONE);

endmodule

// File: rtl/textram_dp.sv
// Dual-port text/colour RAM: byte-wide CPU/fill port A, read-only video port B
// returning VID_BYTES little-endian byte lanes per word.
module textram_dp import textram_pkg::*; #(
  parameter int  CPU_AW    = 12,
  parameter int  VID_BYTES = 2,
  parameter int  FILL_EN   = 1,
  localparam int VID_AW    = CPU_AW - clog2(VID_BYTES)
) (
  input  logic                        clk,
  input  logic                        reset_n,
  textram_if.slave                    cpu_bus,
  input  logic [VID_AW-1:0]           vid_addr,
  output logic [BYTE_W*VID_BYTES-1:0] vid_rddata,
  input  logic                        fill_start,
  input  logic [CPU_AW-1:0]           fill_addr,
  input  logic [CPU_AW:0]             fill_len,
  input  logic [BYTE_W-1:0]           fill_value,
  output logic                        fill_busy,
  output logic                        fill_done
);

  localparam int LANE_W  = clog2(VID_BYTES);
  localparam int LANE_SW = (LANE_W > 0) ? LANE_W : 1;

  logic               r_cpu_ack;
  logic [LANE_SW-1:0] r_rd_lane;
  logic               w_cpu_accept;
  logic               w_cpu_rd;
  logic               w_fill_grant;
  logic               w_fill_req;
  logic [CPU_AW-1:0]  w_fill_addr;
  logic [BYTE_W-1:0]  w_fill_data;
  logic               w_a_we;
  logic [CPU_AW-1:0]  w_a_addr;
  logic [BYTE_W-1:0]  w_a_data;
  logic [LANE_SW-1:0] w_a_lane;
  logic [VID_AW-1:0]  w_a_word;
  logic [BYTE_W-1:0]  w_cpu_lane_q [VID_BYTES];

  // Accepting nothing while reset is low keeps port A quiet in the reset cycle.
  assign w_cpu_accept = reset_n && cpu_bus.cpu_req && !r_cpu_ack;
  assign w_cpu_rd     = w_cpu_accept && !cpu_bus.cpu_wr;
  assign w_fill_grant = reset_n && !w_cpu_accept;

  assign w_a_we   = (w_cpu_accept && cpu_bus.cpu_wr) || (w_fill_req && w_fill_grant);
  assign w_a_addr = w_cpu_accept ? cpu_bus.cpu_addr   : w_fill_addr;
  assign w_a_data = w_cpu_accept ? cpu_bus.cpu_wrdata : w_fill_data;
  assign w_a_lane = LANE_SW'(w_a_addr % CPU_AW'(VID_BYTES));
  assign w_a_word = VID_AW'(w_a_addr >> LANE_W);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cpu_ack <= 1'b0;
      r_rd_lane <= '0;
    end else begin
      r_cpu_ack <= w_cpu_accept;
      if (w_cpu_rd) r_rd_lane <= w_a_lane;
    end
  end

  assign cpu_bus.cpu_ack    = r_cpu_ack;
  assign cpu_bus.cpu_rddata = w_cpu_lane_q[r_rd_lane];

  generate
    for (genvar k = 0; k < VID_BYTES; k++) begin : g_lane
      logic [BYTE_W-1:0] r_mem [2**VID_AW];
      logic [BYTE_W-1:0] r_cpu_q;
      logic [BYTE_W-1:0] r_vid_q;

      // NOTE: the array itself has no reset so it maps onto block RAM;
      // contents deliberately survive reset_n.
      always_ff @(posedge clk) begin
        if (w_a_we && (w_a_lane == LANE_SW'(k))) r_mem[w_a_word] <= w_a_data;
      end

      // Output registers read before the write lands, giving old-data
      // behaviour on a same-cycle video/port-A collision.
      always_ff @(posedge clk) begin
        if (!reset_n) begin
          r_cpu_q <= '0;
          r_vid_q <= '0;
        end else begin
          if (w_cpu_rd) r_cpu_q <= r_mem[w_a_word];
          r_vid_q <= r_mem[vid_addr];
        end
      end

      assign w_cpu_lane_q[k]                 = r_cpu_q;
      assign vid_rddata[BYTE_W*k +: BYTE_W] = r_vid_q;
    end

    if (FILL_EN != 0) begin : g_fill
      textram_fill #(.CPU_AW(CPU_AW)) u_fill (
        .clk        (clk),
        .reset_n    (reset_n),
        .fill_start (fill_start),
        .fill_addr  (fill_addr),
        .fill_len   (fill_len),
        .fill_value (fill_value),
        .i_grant    (w_fill_grant),
        .o_wr_req   (w_fill_req),
        .o_wr_addr  (w_fill_addr),
        .o_wr_data  (w_fill_data),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done)
      );
    end else begin : g_no_fill
      logic w_unused_fill;
      assign w_unused_fill = ^{fill_start, fill_addr, fill_len, fill_value, w_fill_grant};
      assign w_fill_req    = 1'b0;
      assign w_fill_addr   = '0;
      assign w_fill_data   = '0;
      assign fill_busy     = 1'b0;
      assign fill_done     = 1'b0;
    end
  endgenerate

endmodule

// File: tb/tb_textram_dp.sv
// Directed/randomised bench for textram_dp against a byte-array model of the RAM
// and the fill rules (one fill byte per cycle the CPU leaves free).
module tb_textram_dp;

  localparam int CPU_AW = 12;
  localparam int DEPTH  = 1 << CPU_AW;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  textram_if #(.CPU_AW(CPU_AW)) bus ();
  textram_if #(.CPU_AW(CPU_AW)) bus4 ();

  logic [10:0] vid_addr;
  logic [15:0] vid_rddata;
  logic        fill_start;
  logic [11:0] fill_addr;
  logic [12:0] fill_len;
  logic [7:0]  fill_value;
  logic        fill_busy;
  logic        fill_done;
  logic [9:0]  vid_addr4;
  logic [31:0] vid_rddata4;
  logic        fill_busy4;
  logic        fill_done4;

  textram_dp #(.CPU_AW(CPU_AW), .VID_BYTES(2), .FILL_EN(1)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_bus    (bus),
    .vid_addr   (vid_addr),
    .vid_rddata (vid_rddata),
    .fill_start (fill_start),
    .fill_addr  (fill_addr),
    .fill_len   (fill_len),
    .fill_value (fill_value),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  textram_dp #(.CPU_AW(CPU_AW), .VID_BYTES(4), .FILL_EN(1)) dut4 (
    .clk        (clk),
    .reset_n    (reset_n),
    .cpu_bus    (bus4),
    .vid_addr   (vid_addr4),
    .vid_rddata (vid_rddata4),
    .fill_start (1'b0),
    .fill_addr  (12'h000),
    .fill_len   (13'h0000),
    .fill_value (8'h00),
    .fill_busy  (fill_busy4),
    .fill_done  (fill_done4)
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  int         busy_cnt = 0;
  int         done_cnt = 0;
  logic [7:0] model [DEPTH];
  logic [7:0] last_rd;

  always @(negedge clk) begin
    if (fill_busy === 1'b1) busy_cnt++;
    if (fill_done === 1'b1) done_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] vid_word(input logic [10:0] w);
    return {model[{w, 1'b1}], model[{w, 1'b0}]};
  endfunction

  // One CPU access: accept at the first edge, ack in the following cycle,
  // request dropped in the ack cycle so the next access can follow at once.
  task automatic cpu_op(input logic wr, input logic [11:0] addr, input logic [7:0] data,
                        input logic chk_vid);
    logic [15:0] vid_old;
    vid_old = vid_word(vid_addr);
    bus.cpu_req = 1'b1;
    bus.cpu_wr = wr;
    bus.cpu_addr = addr;
    bus.cpu_wrdata = data;
    tick();
    check("cpu_ack", bus.cpu_ack, 1);
    if (wr) model[addr] = data;
    else    last_rd = model[addr];
    check("cpu_rddata", bus.cpu_rddata, last_rd);
    if (chk_vid) check("vid_collision_old", vid_rddata, vid_old);
    bus.cpu_req = 1'b0;
    tick();
    check("cpu_ack_pulse", bus.cpu_ack, 0);
    if (chk_vid) check("vid_after_write", vid_rddata, vid_word(vid_addr));
  endtask

  task automatic start_fill(input logic [11:0] a, input logic [12:0] len, input logic [7:0] v);
    fill_start = 1'b1;
    fill_addr  = a;
    fill_len   = len;
    fill_value = v;
    tick();
    fill_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int budget);
    int n;
    n = 0;
    while (done_cnt == base && n < budget) begin
      tick();
      n++;
    end
    check("fill_done_seen", done_cnt - base, 1);
  endtask

  initial begin
    int          base_b;
    int          base_d;
    int          bad;
    logic        wr;
    logic [11:0] a;
    logic [7:0]  d;

    reset_n = 1'b0;
    bus.cpu_req = 1'b0;  bus.cpu_wr = 1'b0;  bus.cpu_addr = '0;  bus.cpu_wrdata = '0;
    bus4.cpu_req = 1'b0; bus4.cpu_wr = 1'b0; bus4.cpu_addr = '0; bus4.cpu_wrdata = '0;
    vid_addr = '0; vid_addr4 = '0;
    fill_start = 1'b0; fill_addr = '0; fill_len = '0; fill_value = '0;
    last_rd = 8'h00;
    tick(3);

    check("rst_ack", bus.cpu_ack, 0);
    check("rst_rddata", bus.cpu_rddata, 0);
    check("rst_vid", vid_rddata, 0);
    check("rst_busy", fill_busy, 0);
    check("rst_done", fill_done, 0);
    check("rst_vid4", vid_rddata4, 0);
    check("rst_ack4", bus4.cpu_ack, 0);
    reset_n = 1'b1;
    tick();

    // Whole-RAM fill with the CPU idle puts the RAM in a known state.
    base_b = busy_cnt; base_d = done_cnt;
    start_fill(12'h000, 13'h1000, 8'hA5);
    wait_done(base_d, 5000);
    check("init_busy_cycles", busy_cnt - base_b, 4096);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'hA5;

    cpu_op(1'b1, 12'h123, 8'h41, 1'b0);
    cpu_op(1'b0, 12'h123, 8'h00, 1'b0);
    check("rd_0x123", bus.cpu_rddata, 8'h41);
    vid_addr = 11'h091;
    tick();
    check("vid_0x123_hi", vid_rddata[15:8], 8'h41);
    check("vid_0x091", vid_rddata, 16'h41A5);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 12'($urandom);
      d  = 8'($urandom);
      vid_addr = ($urandom_range(0, 1) == 1) ? a[11:1] : 11'($urandom);
      cpu_op(wr, a, d, 1'b1);
    end

    for (int i = 0; i < 4; i++) begin
      bus4.cpu_req = 1'b1; bus4.cpu_wr = 1'b1;
      bus4.cpu_addr = 12'(i); bus4.cpu_wrdata = 8'(8'h11 * (i + 1));
      tick();
      check("ack4", bus4.cpu_ack, 1);
      bus4.cpu_req = 1'b0;
      tick();
    end
    vid_addr4 = '0;
    tick();
    check("lane4_word0", vid_rddata4, 32'h44332211);

    // Wrapping fill across the top of the address space.
    base_b = busy_cnt; base_d = done_cnt;
    start_fill(12'hFFE, 13'd4, 8'h20);
    wait_done(base_d, 20);
    check("wrap_busy_cycles", busy_cnt - base_b, 4);
    tick(2);
    check("wrap_done_once", done_cnt - base_d, 1);
    for (int i = 0; i < 4; i++) model[12'(12'hFFE + i)] = 8'h20;
    cpu_op(1'b0, 12'hFFE, 8'h00, 1'b0);
    check("wrap_ffe", bus.cpu_rddata, 8'h20);
    cpu_op(1'b0, 12'hFFF, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h000, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h001, 8'h00, 1'b0);
    check("wrap_001", bus.cpu_rddata, 8'h20);
    cpu_op(1'b0, 12'h002, 8'h00, 1'b0);

    // Zero-length fill completes at once without writing.
    base_b = busy_cnt; base_d = done_cnt;
    start_fill(12'h400, 13'd0, 8'hEE);
    check("len0_done", fill_done, 1);
    check("len0_busy", fill_busy, 0);
    tick();
    check("len0_done_pulse", fill_done, 0);
    check("len0_busy_cycles", busy_cnt - base_b, 0);
    cpu_op(1'b0, 12'h400, 8'h00, 1'b0);

    // A second start while busy must be ignored.
    base_b = busy_cnt; base_d = done_cnt;
    start_fill(12'h300, 13'd8, 8'h77);
    tick(2);
    check("busy_mid_fill", fill_busy, 1);
    start_fill(12'h500, 13'd8, 8'h99);
    wait_done(base_d, 50);
    check("ignore_busy_cycles", busy_cnt - base_b, 8);
    tick(3);
    check("ignore_done_once", done_cnt - base_d, 1);
    check("ignore_idle", fill_busy, 0);
    for (int i = 0; i < 8; i++) model[12'h300 + i] = 8'h77;
    cpu_op(1'b0, 12'h300, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h307, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h308, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h500, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h507, 8'h00, 1'b0);

    // Reset after three fill writes.
    base_d = done_cnt;
    start_fill(12'h600, 13'd16, 8'h3C);
    tick(3);
    reset_n = 1'b0;
    tick();
    check("rstmid_busy", fill_busy, 0);
    check("rstmid_done", fill_done, 0);
    check("rstmid_ack", bus.cpu_ack, 0);
    check("rstmid_rddata", bus.cpu_rddata, 0);
    check("rstmid_vid", vid_rddata, 0);
    last_rd = 8'h00;
    reset_n = 1'b1;
    tick(2);
    check("rstmid_no_done", done_cnt - base_d, 0);
    for (int i = 0; i < 3; i++) model[12'h600 + i] = 8'h3C;
    cpu_op(1'b0, 12'h600, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h602, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h603, 8'h00, 1'b0);
    cpu_op(1'b0, 12'h60F, 8'h00, 1'b0);

    // Whole-RAM fill while the CPU accesses every second cycle, well ahead of
    // the fill pointer; each CPU access costs the fill exactly one cycle.
    base_b = busy_cnt; base_d = done_cnt;
    start_fill(12'h000, 13'h1000, 8'h20);
    for (int i = 0; i < 500; i++) begin
      a = 12'h C00 + 12'($urandom_range(0, 12'h3FF));
      cpu_op(1'(i % 2 == 0), a, 8'($urandom), 1'b0);
    end
    wait_done(base_d, 10000);
    check("full_busy_cycles", busy_cnt - base_b, 4096 + 500);
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h20;
    cpu_op(1'b0, a, 8'h00, 1'b0);
    check("full_cpu_byte", bus.cpu_rddata, 8'h20);
    bad = 0;
    for (int w = 0; w < DEPTH / 2; w++) begin
      vid_addr = 11'(w);
      tick();
      if (vid_rddata !== vid_word(11'(w))) bad++;
    end
    check("full_sweep_bad_words", bad, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
